// File: rtl/pio_write_arbiter_if.sv
// Avalon-MM bus between the arbiter (master) and the 7-bit output PIO (slave).
// Address and data widths follow the PIO register map: 2-bit address, 32-bit data.
interface pio_write_arbiter_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that shares one output PIO among NUM_REQ clients:
// write, read-back verify, then hold the value for HOLD_CYCLES before the next grant.
module pio_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 7,
  parameter int HOLD_CYCLES = 16,
  parameter int IDX_W       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  pio_write_arbiter_if.master       avm,
  output logic                      busy,
  output logic [IDX_W-1:0]          last_grant,
  output logic                      verify_err,
  input  logic                      err_clr
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, sel, rr_ptr_nxt;
  logic                found;
  logic [DATA_W-1:0]   sel_data, payload_q;
  logic [CNT_W-1:0]    hold_cnt_q;
  logic                mismatch;

  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                cs_q, cs_d, wn_q, wn_d, busy_q, busy_d;
  logic [31:0]         wd_q, wd_d;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  assign sel_data   = req_data[int'(sel)*DATA_W +: DATA_W];
  assign rr_ptr_nxt = IDX_W'((int'(sel) + 1) % NUM_REQ);
  assign mismatch   = avm.avm_readdata[DATA_W-1:0] != payload_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = WRITE;
      WRITE:   state_d = VERIFY;
      VERIFY:  state_d = HOLD;
      HOLD:    if (hold_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered bus outputs are computed from the state being entered.
  always_comb begin
    ack_d  = '0;
    cs_d   = (state_d == WRITE) || (state_d == VERIFY);
    wn_d   = (state_d != WRITE);
    wd_d   = wd_q;
    busy_d = (state_d != IDLE);
    if (state_q == IDLE && found) begin
      ack_d[sel] = 1'b1;
      wd_d       = {{(32-DATA_W){1'b0}}, sel_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      payload_q  <= '0;
      hold_cnt_q <= '0;
      last_grant <= '0;
      verify_err <= 1'b0;
      ack_q      <= '0;
      cs_q       <= 1'b0;
      wn_q       <= 1'b1;
      wd_q       <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      if (state_q == IDLE && found) begin
        payload_q  <= sel_data;
        last_grant <= sel;
        rr_ptr_q   <= rr_ptr_nxt;
      end
      if (state_q == VERIFY)
        hold_cnt_q <= CNT_W'(HOLD_CYCLES - 1);
      else if (state_q == HOLD && hold_cnt_q != '0)
        hold_cnt_q <= hold_cnt_q - 1'b1;
      // A fresh mismatch outranks a simultaneous clear.
      if (state_q == VERIFY && mismatch)
        verify_err <= 1'b1;
      else if (err_clr)
        verify_err <= 1'b0;
    end
  end

  assign ack                = ack_q;
  assign busy               = busy_q;
  assign avm.avm_address    = 2'b00;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write_n    = wn_q;
  assign avm.avm_writedata  = wd_q;

endmodule
